// File: rtl/dct_mac_seq.sv
// dct_mac_seq: sequences a TAPS-step multiply-accumulate unit and captures its result.
// Optional feature: define DCT_MAC_SEQ_PERF_EN to add the perf_jobs result-handshake counter.
//
// state | meaning
// IDLE  | waiting for a job, start_ready follows ena
// ISSUE | one MAC per enabled cycle, coef_idx 0..TAPS-1
// DRAIN | down-counting MAC_LAT cycles until acc_in is valid
// HOLD  | res_data presented until the consumer takes it
module dct_mac_seq #(
  parameter int TAPS    = 8,
  parameter int MAC_LAT = 2,
  parameter int RES_W   = 12
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ena,
  input  logic                    start_valid,
  output logic                    start_ready,
  output logic                    mac_clr,
  output logic                    mac_ena,
  output logic [$clog2(TAPS)-1:0] coef_idx,
  input  logic [RES_W-1:0]        acc_in,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [RES_W-1:0]        res_data,
  output logic                    busy
`ifdef DCT_MAC_SEQ_PERF_EN
  ,
  output logic [15:0]             perf_jobs
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, HOLD} state_t;

  localparam int              CW         = $clog2(TAPS);
  localparam logic [CW-1:0]   LAST_TAP   = CW'(TAPS - 1);
  localparam logic [2:0]      DRAIN_LOAD = 3'(MAC_LAT - 1);

  state_t     state;
  logic [2:0] drain_cnt;
  logic       res_hs;

  // MAC strobes are gated by ena so a stalled tap is simply reissued later.
  assign start_ready = (state == IDLE) & ena;
  assign mac_ena     = (state == ISSUE) & ena;
  assign mac_clr     = mac_ena & (coef_idx == '0);
  assign res_valid   = (state == HOLD);
  assign busy        = (state != IDLE);
  assign res_hs      = res_valid & res_ready & ena;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      coef_idx  <= '0;
      drain_cnt <= '0;
      res_data  <= '0;
    end else if (ena) begin
      unique case (state)
        IDLE: begin
          if (start_valid) begin
            coef_idx <= '0;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (coef_idx == LAST_TAP) begin
            coef_idx  <= '0;
            drain_cnt <= DRAIN_LOAD;
            state     <= DRAIN;
          end else begin
            coef_idx <= coef_idx + 1'b1;
          end
        end
        DRAIN: begin
          if (drain_cnt == '0) begin
            res_data <= acc_in;
            state    <= HOLD;
          end else begin
            drain_cnt <= drain_cnt - 1'b1;
          end
        end
        HOLD: begin
          if (res_hs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DCT_MAC_SEQ_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_jobs <= '0;
    end else if (res_hs && (perf_jobs != 16'hFFFF)) begin
      perf_jobs <= perf_jobs + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dct_mac_seq.sv
// Scoreboard bench for dct_mac_seq at default parameters: stimulus pushes expected
// results, a monitor pops them on each result handshake.
module tb_dct_mac_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic        start_valid;
  logic        start_ready;
  logic        mac_clr;
  logic        mac_ena;
  logic [2:0]  coef_idx;
  logic [11:0] acc_in;
  logic        res_valid;
  logic        res_ready;
  logic [11:0] res_data;
  logic        busy;
`ifdef DCT_MAC_SEQ_PERF_EN
  logic [15:0] perf_jobs;
`endif

  dct_mac_seq #(.TAPS(8), .MAC_LAT(2), .RES_W(12)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .mac_clr     (mac_clr),
    .mac_ena     (mac_ena),
    .coef_idx    (coef_idx),
    .acc_in      (acc_in),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .busy        (busy)
`ifdef DCT_MAC_SEQ_PERF_EN
    ,
    .perf_jobs   (perf_jobs)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [11:0] data;
    int          rise_cyc;
  } sb_t;

  sb_t sb_q[$];
  int  n_cmp  = 0;
  int  n_bad  = 0;
  int  hs_cnt = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Result monitor: latency measured from the first cycle res_valid is seen.
  initial begin : monitor
    logic prev_v;
    int   rise;
    sb_t  e;
    prev_v = 1'b0;
    rise   = 0;
    forever begin
      @(negedge clk);
      if (res_valid && !prev_v) rise = cyc;
      prev_v = res_valid;
      if (res_valid && res_ready && ena) begin
        hs_cnt++;
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_result: got %0h, expected no result (cycle %0d)", res_data, cyc);
        end else begin
          e = sb_q.pop_front();
          check("res_data", res_data, e.data);
          check("res_latency", rise, e.rise_cyc);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000 ns");
    $fatal(1, "watchdog expired");
  end

  // One job; acc_in carries the real result only on the capture cycle.
  task automatic do_job(input logic [11:0] data, input int stall_idx,
                        input int stall_len, input int bp_len);
    int t0;
    int extra;
    tick();
    start_valid = 1'b1;
    ena         = 1'b1;
    res_ready   = 1'b1;
    acc_in      = ~data;
    @(negedge clk);
    check("start_ready_idle", start_ready, 1);
    t0    = cyc;
    extra = (stall_idx >= 0) ? stall_len : 0;
    sb_q.push_back('{data, t0 + 11 + extra});
    for (int i = 0; i < 8; i++) begin
      tick();
      start_valid = 1'b0;
      if (i == stall_idx) begin
        for (int s = 0; s < stall_len; s++) begin
          ena = 1'b0;
          @(negedge clk);
          check("stall_mac_ena", mac_ena, 0);
          check("stall_mac_clr", mac_clr, 0);
          check("stall_coef_idx", coef_idx, i);
          tick();
        end
        ena = 1'b1;
      end
      @(negedge clk);
      check("issue_mac_ena", mac_ena, 1);
      check("issue_coef_idx", coef_idx, i);
      check("issue_mac_clr", mac_clr, (i == 0));
    end
    for (int d = 0; d < 2; d++) begin
      tick();
      acc_in = (d == 1) ? data : ~data;
      @(negedge clk);
      check("drain_mac_ena", mac_ena, 0);
      check("drain_coef_idx", coef_idx, 0);
      check("drain_busy", busy, 1);
      check("drain_res_valid", res_valid, 0);
    end
    tick();
    acc_in    = ~data;
    res_ready = (bp_len == 0);
    @(negedge clk);
    check("hold_res_valid", res_valid, 1);
    check("hold_res_data", res_data, data);
    check("hold_start_ready", start_ready, 0);
    for (int b = 1; b < bp_len; b++) begin
      tick();
      @(negedge clk);
      check("bp_res_valid", res_valid, 1);
      check("bp_res_data", res_data, data);
      check("bp_start_ready", start_ready, 0);
    end
    if (bp_len > 0) begin
      tick();
      res_ready = 1'b1;
      @(negedge clk);
      check("bp_release_valid", res_valid, 1);
      check("bp_release_data", res_data, data);
    end
    tick();
    @(negedge clk);
    check("post_busy", busy, 0);
    check("post_res_valid", res_valid, 0);
    check("post_start_ready", start_ready, 1);
  endtask

  initial begin : stim
    int accepts;
    int last_acc;
    int guard;
    int hs_before;
    rst_n       = 1'b0;
    ena         = 1'b1;
    start_valid = 1'b0;
    res_ready   = 1'b1;
    acc_in      = 12'h000;
    tick();
    tick();
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_mac_ena", mac_ena, 0);
    check("rst_coef_idx", coef_idx, 0);
    tick();
    rst_n = 1'b1;

    do_job(12'h3A5, -1, 0, 0);
    do_job(12'h6C1, -1, 0, 5);
    do_job(12'h2B7, 4, 3, 0);

    // Abandon a job at coef_idx 5 with an asynchronous reset.
    tick();
    start_valid = 1'b1;
    @(negedge clk);
    check("rj_start_ready", start_ready, 1);
    tick();
    start_valid = 1'b0;
    repeat (5) tick();
    @(negedge clk);
    check("rj_coef_idx", coef_idx, 5);
    #1 rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_mac_ena", mac_ena, 0);
    check("arst_mac_clr", mac_clr, 0);
    check("arst_coef_idx", coef_idx, 0);
    check("arst_res_valid", res_valid, 0);
    check("arst_res_data", res_data, 0);
    check("arst_start_ready", start_ready, 1);
`ifdef DCT_MAC_SEQ_PERF_EN
    check("arst_perf_jobs", perf_jobs, 0);
`endif
    tick();
    tick();
    rst_n = 1'b1;
    do_job(12'h0F0, -1, 0, 0);

    // Back-to-back jobs with start_valid held high.
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    hs_before = hs_cnt;
    tick();
    start_valid = 1'b1;
    res_ready   = 1'b1;
    acc_in      = 12'h5C3;
    accepts  = 0;
    last_acc = 0;
    guard    = 0;
    while (accepts < 3 && guard < 100) begin
      @(negedge clk);
      if (start_valid && start_ready) begin
        if (accepts > 0) check("b2b_accept_gap", cyc - last_acc, 12);
        last_acc = cyc;
        accepts++;
        sb_q.push_back('{12'h5C3, cyc + 11});
      end
      tick();
      if (accepts == 3) start_valid = 1'b0;
      guard++;
    end
    check("b2b_accepts", accepts, 3);
    guard = 0;
    while (guard < 40) begin
      @(negedge clk);
      if (!busy) break;
      tick();
      guard++;
    end
    check("b2b_drain_timeout", (guard < 40), 1);
    repeat (3) tick();
    check("b2b_handshakes", hs_cnt - hs_before, 3);
`ifdef DCT_MAC_SEQ_PERF_EN
    check("perf_jobs", perf_jobs, 3);
`endif
    check("sb_empty", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dct_mac_seq.md
DCT_MAC_SEQ -- requirements
Module: dct_mac_seq

Interface
REQ-001 SHALL have parameter TAPS, default 8: MAC steps per dot product, range 2..16.
REQ-002 SHALL have parameter MAC_LAT, default 2: macu cycles from the last mac_ena to a valid acc_in, range 1..4.
REQ-003 SHALL have parameter RES_W, default 12: result width.
REQ-004 SHALL have port clk, input, 1: single clock, all state on the rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port ena, input, 1: global clock enable; low freezes all state.
REQ-007 SHALL have port start_valid, input, 1: a dot-product job is requested.
REQ-008 SHALL have port start_ready, output, 1: the sequencer accepts a job.
REQ-009 SHALL have port mac_clr, output, 1: clears the macu accumulator on the first tap.
REQ-010 SHALL have port mac_ena, output, 1: the macu performs one multiply-accumulate this cycle.
REQ-011 SHALL have port coef_idx, output, $clog2(TAPS): coefficient and sample index for the current tap.
REQ-012 SHALL have port acc_in, input, RES_W: the macu result register.
REQ-013 SHALL have port res_valid, output, 1: res_data holds a completed result.
REQ-014 SHALL have port res_ready, input, 1: the consumer accepts the result.
REQ-015 SHALL have port res_data, output, RES_W: the captured dot-product result.
REQ-016 SHALL have port busy, output, 1: high in any state other than IDLE.

Function
REQ-017 SHALL implement the states IDLE, ISSUE, DRAIN and HOLD; every transition occurs only in cycles where ena=1.
REQ-018 SHALL drive start_ready = (state==IDLE) & ena; a job is accepted when start_valid & start_ready, and the next state is ISSUE.
REQ-019 ISSUE SHALL last exactly TAPS enabled cycles, with mac_ena=1, coef_idx counting 0..TAPS-1, and mac_clr=1 only when coef_idx==0.
REQ-020 After coef_idx==TAPS-1, the block SHALL enter DRAIN, which lasts exactly MAC_LAT enabled cycles with mac_ena=0.
REQ-021 On the last DRAIN cycle, the block SHALL capture acc_in into res_data and enter HOLD with res_valid=1.
REQ-022 In HOLD, res_valid and res_data SHALL stay stable until res_valid & res_ready & ena; the next state is then IDLE.
REQ-023 End-to-end latency with ena held high SHALL be: job accepted in cycle T gives res_valid=1 in cycle T+1+TAPS+MAC_LAT (T+11 at default parameters).
REQ-024 When ena=0, mac_ena and mac_clr SHALL be 0 and the counters, state and res_data SHALL hold; a stalled tap is reissued with the same coef_idx.
REQ-025 start_valid in any state other than IDLE SHALL be ignored with no side effects; only one job is in flight at a time.
REQ-026 The coef_idx counter SHALL return to 0 on leaving ISSUE and SHALL never exceed TAPS-1.
REQ-027 In IDLE, DRAIN and HOLD, mac_ena, mac_clr and coef_idx SHALL be 0.

Reset
REQ-028 rst_n=0 SHALL immediately force IDLE, with coef_idx=0, drain counter=0, mac_ena=0, mac_clr=0, res_valid=0, res_data=0 and busy=0.
REQ-029 Reset asserted mid-job SHALL abandon the job with no result produced; the first job accepted after reset SHALL start cleanly with mac_clr.

Configuration
REQ-030 With macro DCT_MAC_SEQ_PERF_EN defined, the block SHALL add output perf_jobs, 16 bits, reset 0, which increments on each result handshake and saturates at 16'hFFFF.
REQ-031 Without DCT_MAC_SEQ_PERF_EN, perf_jobs and its logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-032 Bench SHALL cover a single job (ena=1, res_ready=1, acc_in=12'h3A5 at capture): accepted in cycle 0, then mac_clr in cycle 1 only, coef_idx 0..7 in cycles 1..8, res_valid in cycle 11 with res_data=12'h3A5.
REQ-033 Bench SHALL cover back-pressure (res_ready=0 for 5 cycles): res_valid and res_data stay stable, start_ready=0, and the state returns to IDLE the cycle after res_ready=1.
REQ-034 Bench SHALL cover a stall (ena=0 for 3 cycles while coef_idx=4): no mac_ena during the stall, coef_idx=4 reissued, and res_valid delayed by exactly 3 cycles to cycle 14.
REQ-035 Bench SHALL cover reset mid-job (rst_n=0 asynchronously at coef_idx=5): all outputs reach their reset values without a clock edge, and the next job begins with mac_clr and coef_idx=0.
REQ-036 Bench SHALL cover three back-to-back jobs with start_valid held at 1: each job is accepted only in IDLE, giving three result handshakes, and with DCT_MAC_SEQ_PERF_EN defined perf_jobs=3.
